// File: rtl/spq_pkg.sv
// -----------------------------------------------------------------------------
// spq_pkg
// Shared constants, types and helpers for the static priority queue.
//   SPQ_DEPTH / SPQ_ENQ_WIDTH / SPQ_SEL_WIDTH / SPQ_DATA_WIDTH : default geometry
//   spq_idx_t          : entry index ($clog2(depth) bits)
//   spq_cnt_t          : occupancy count ($clog2(depth+1) bits)
//   spq_onehot_to_idx  : one-hot entry mask -> entry index (0 for an empty mask)
// Optional feature macro used by the top: SPQ_OCCUPANCY_EN.
// -----------------------------------------------------------------------------
package spq_pkg;

   localparam int SPQ_DEPTH      = 8;
   localparam int SPQ_ENQ_WIDTH  = 2;
   localparam int SPQ_SEL_WIDTH  = 2;
   localparam int SPQ_DATA_WIDTH = 32;
   localparam int SPQ_IDX_W      = $clog2(SPQ_DEPTH);
   localparam int SPQ_CNT_W      = $clog2(SPQ_DEPTH + 1);

   typedef logic [SPQ_IDX_W-1:0] spq_idx_t;
   typedef logic [SPQ_CNT_W-1:0] spq_cnt_t;

   // OR of the indices of all set bits; for a one-hot mask this is the index,
   // and an all-zero mask yields index 0 as required for an idle port.
   function automatic spq_idx_t spq_onehot_to_idx(input logic [SPQ_DEPTH-1:0] onehot);
      spq_idx_t idx;
      idx = {SPQ_IDX_W{1'b0}};
      for (int i = 0; i < SPQ_DEPTH; i++) begin
         if (onehot[i]) begin
            idx = idx | spq_idx_t'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/static_priority_selector.sv
// -----------------------------------------------------------------------------
// static_priority_selector
// Purely combinational lowest-index-first selector.
//   entry_vld_i   [Depth]          : occupied entries
//   sel_mask_i    [Depth]          : entries eligible for selection
//   enq_mask_o    [EnqWidth*Depth] : port k one-hot = k-th lowest free entry
//   result_mask_o [SelWidth*Depth] : port j one-hot = j-th lowest eligible entry
// A port with nothing to offer gets an all-zero mask.
// -----------------------------------------------------------------------------
module static_priority_selector #(
   parameter int Depth    = 8,
   parameter int EnqWidth = 2,
   parameter int SelWidth = 2
) (
   input  logic [Depth-1:0]          entry_vld_i,
   input  logic [Depth-1:0]          sel_mask_i,
   output logic [EnqWidth*Depth-1:0] enq_mask_o,
   output logic [SelWidth*Depth-1:0] result_mask_o
);

   logic [Depth-1:0] free_s;
   logic [Depth-1:0] ready_s;
   logic             taken_s;

   // Peel off the lowest free slot per enqueue port and the lowest eligible
   // entry per dequeue port; each pick is removed before the next port looks.
   always_comb begin
      enq_mask_o    = {(EnqWidth*Depth){1'b0}};
      result_mask_o = {(SelWidth*Depth){1'b0}};
      free_s        = ~entry_vld_i;
      ready_s       = sel_mask_i;
      taken_s       = 1'b0;
      for (int k = 0; k < EnqWidth; k++) begin
         taken_s = 1'b0;
         for (int e = 0; e < Depth; e++) begin
            if (free_s[e] && !taken_s) begin
               enq_mask_o[k*Depth + e] = 1'b1;
               free_s[e]               = 1'b0;
               taken_s                 = 1'b1;
            end else begin
               enq_mask_o[k*Depth + e] = 1'b0;
            end
         end
      end
      for (int j = 0; j < SelWidth; j++) begin
         taken_s = 1'b0;
         for (int e = 0; e < Depth; e++) begin
            if (ready_s[e] && !taken_s) begin
               result_mask_o[j*Depth + e] = 1'b1;
               ready_s[e]                 = 1'b0;
               taken_s                    = 1'b1;
            end else begin
               result_mask_o[j*Depth + e] = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/static_priority_queue.sv
// -----------------------------------------------------------------------------
// static_priority_queue
// Non-collapsing issue buffer: allocates free slots lowest-index first and
// presents issuable entries lowest-index first on the dequeue ports.
//   clk, rstn (async active-low), flush_i (synchronous clear)
//   enq_vld_i/enq_issuable_i/enq_data_i -> enq_rdy_o   : enqueue ports
//   wake_i                                             : per-entry issuable set
//   deq_vld_o/deq_data_o/deq_idx_o <- deq_rdy_i        : dequeue ports
//   full_o, empty_o                                    : occupancy flags
//   count_o                                            : only with SPQ_OCCUPANCY_EN
// All outputs depend on registered state only.
// The index helper in spq_pkg is sized for SPQ_DEPTH; Depth must match it.
// -----------------------------------------------------------------------------
module static_priority_queue
   import spq_pkg::*;
#(
   parameter int Depth     = SPQ_DEPTH,
   parameter int EnqWidth  = SPQ_ENQ_WIDTH,
   parameter int SelWidth  = SPQ_SEL_WIDTH,
   parameter int DataWidth = SPQ_DATA_WIDTH
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                flush_i,
   input  logic [EnqWidth-1:0]                 enq_vld_i,
   input  logic [EnqWidth-1:0]                 enq_issuable_i,
   input  logic [EnqWidth*DataWidth-1:0]       enq_data_i,
   output logic [EnqWidth-1:0]                 enq_rdy_o,
   input  logic [Depth-1:0]                    wake_i,
   output logic [SelWidth-1:0]                 deq_vld_o,
   input  logic [SelWidth-1:0]                 deq_rdy_i,
   output logic [SelWidth*DataWidth-1:0]       deq_data_o,
   output logic [SelWidth*$clog2(Depth)-1:0]   deq_idx_o,
   output logic                                full_o,
   output logic                                empty_o
`ifdef SPQ_OCCUPANCY_EN
   ,
   output logic [$clog2(Depth+1)-1:0]          count_o
`endif
);

   localparam int IdxW = $clog2(Depth);

   logic [Depth-1:0]          vld_q, vld_d;
   logic [Depth-1:0]          iss_q, iss_d;
   logic [DataWidth-1:0]      data_q [Depth];
   logic [DataWidth-1:0]      data_d [Depth];

   logic [EnqWidth*Depth-1:0] enq_mask_s;
   logic [SelWidth*Depth-1:0] result_mask_s;
   logic [EnqWidth-1:0]       enq_fire_s;
   logic [SelWidth-1:0]       deq_fire_s;
   logic [Depth-1:0]          enq_hit_s;
   logic [Depth-1:0]          enq_iss_s;
   logic [DataWidth-1:0]      enq_dat_s [Depth];
   logic [Depth-1:0]          deq_hit_s;
   logic                      sel_s;

   // Masks come from registered vld only, so a slot freed this cycle is not
   // handed out again until the next one.
   static_priority_selector #(
      .Depth    (Depth),
      .EnqWidth (EnqWidth),
      .SelWidth (SelWidth)
   ) u_selector (
      .entry_vld_i   (vld_q),
      .sel_mask_i    (vld_q & iss_q),
      .enq_mask_o    (enq_mask_s),
      .result_mask_o (result_mask_s)
   );

   // Enqueue handshakes and their per-entry write decode.
   always_comb begin
      enq_rdy_o  = {EnqWidth{1'b0}};
      enq_fire_s = {EnqWidth{1'b0}};
      enq_hit_s  = {Depth{1'b0}};
      enq_iss_s  = {Depth{1'b0}};
      sel_s      = 1'b0;
      for (int e = 0; e < Depth; e++) begin
         enq_dat_s[e] = {DataWidth{1'b0}};
      end
      for (int k = 0; k < EnqWidth; k++) begin
         enq_rdy_o[k]  = |enq_mask_s[k*Depth +: Depth];
         enq_fire_s[k] = enq_vld_i[k] & enq_rdy_o[k];
         for (int e = 0; e < Depth; e++) begin
            sel_s        = enq_fire_s[k] & enq_mask_s[k*Depth + e];
            enq_hit_s[e] = enq_hit_s[e] | sel_s;
            enq_iss_s[e] = enq_iss_s[e] | (sel_s & enq_issuable_i[k]);
            enq_dat_s[e] = enq_dat_s[e] |
                           ({DataWidth{sel_s}} & enq_data_i[k*DataWidth +: DataWidth]);
         end
      end
   end

   // Dequeue port muxes and handshakes; idle ports drive zero data and index.
   always_comb begin
      deq_vld_o  = {SelWidth{1'b0}};
      deq_fire_s = {SelWidth{1'b0}};
      deq_data_o = {(SelWidth*DataWidth){1'b0}};
      deq_idx_o  = {(SelWidth*IdxW){1'b0}};
      deq_hit_s  = {Depth{1'b0}};
      for (int j = 0; j < SelWidth; j++) begin
         deq_vld_o[j]  = |result_mask_s[j*Depth +: Depth];
         deq_fire_s[j] = deq_vld_o[j] & deq_rdy_i[j];
         deq_idx_o[j*IdxW +: IdxW] =
            IdxW'(spq_onehot_to_idx(SPQ_DEPTH'(result_mask_s[j*Depth +: Depth])));
         for (int e = 0; e < Depth; e++) begin
            deq_data_o[j*DataWidth +: DataWidth] = deq_data_o[j*DataWidth +: DataWidth] |
               ({DataWidth{result_mask_s[j*Depth + e]}} & data_q[e]);
            deq_hit_s[e] = deq_hit_s[e] | (deq_fire_s[j] & result_mask_s[j*Depth + e]);
         end
      end
   end

   // Next entry state: flush beats dequeue, dequeue beats enqueue/wake.
   // Wake only lands on entries that are valid or arriving this cycle.
   always_comb begin
      vld_d = vld_q;
      iss_d = iss_q;
      for (int e = 0; e < Depth; e++) begin
         data_d[e] = data_q[e];
         if (flush_i) begin
            vld_d[e] = 1'b0;
            iss_d[e] = 1'b0;
         end else if (deq_hit_s[e]) begin
            vld_d[e] = 1'b0;
            iss_d[e] = 1'b0;
         end else if (enq_hit_s[e]) begin
            vld_d[e]  = 1'b1;
            iss_d[e]  = enq_iss_s[e] | wake_i[e];
            data_d[e] = enq_dat_s[e];
         end else begin
            iss_d[e] = iss_q[e] | (wake_i[e] & vld_q[e]);
         end
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= {Depth{1'b0}};
         iss_q <= {Depth{1'b0}};
         for (int e = 0; e < Depth; e++) begin
            data_q[e] <= {DataWidth{1'b0}};
         end
      end else begin
         vld_q <= vld_d;
         iss_q <= iss_d;
         for (int e = 0; e < Depth; e++) begin
            data_q[e] <= data_d[e];
         end
      end
   end

   assign full_o  = &vld_q;
   assign empty_o = ~|vld_q;

`ifdef SPQ_OCCUPANCY_EN
   localparam int CntW = $clog2(Depth + 1);

   logic [CntW-1:0] count_q, count_d;

   // Occupancy tracks accepted handshakes; both sides are bounded by slot
   // availability, so the count stays within 0..Depth.
   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = {CntW{1'b0}};
      end else begin
         for (int k = 0; k < EnqWidth; k++) begin
            count_d = count_d + CntW'(enq_fire_s[k]);
         end
         for (int j = 0; j < SelWidth; j++) begin
            count_d = count_d - CntW'(deq_fire_s[j]);
         end
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= {CntW{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
`endif

endmodule

// File: tb/tb_static_priority_queue.sv
// -----------------------------------------------------------------------------
// tb_static_priority_queue
// Drives directed and random traffic; a queue-level reference model predicts
// each cycle's outputs, which a separate monitor compares against the DUT.
// Build with SPQ_OCCUPANCY_EN defined to also check count_o.
// -----------------------------------------------------------------------------
module tb_static_priority_queue;

   localparam int D  = 8;
   localparam int DW = 32;

   typedef struct {
      logic [1:0]  deq_vld;
      logic [5:0]  deq_idx;
      logic [63:0] deq_data;
      logic [1:0]  enq_rdy;
      logic        full;
      logic        empty;
      logic [3:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        flush_i;
   logic [1:0]  enq_vld_i;
   logic [1:0]  enq_issuable_i;
   logic [63:0] enq_data_i;
   logic [1:0]  enq_rdy_o;
   logic [7:0]  wake_i;
   logic [1:0]  deq_vld_o;
   logic [1:0]  deq_rdy_i;
   logic [63:0] deq_data_o;
   logic [5:0]  deq_idx_o;
   logic        full_o;
   logic        empty_o;
`ifdef SPQ_OCCUPANCY_EN
   logic [3:0]  count_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one record per slot.
   bit          m_vld  [D];
   bit          m_iss  [D];
   logic [31:0] m_data [D];

   exp_t exp_q [$];
   exp_t mon_e;

   always #5 clk = ~clk;

   static_priority_queue #(
      .Depth     (8),
      .EnqWidth  (2),
      .SelWidth  (2),
      .DataWidth (32)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .flush_i        (flush_i),
      .enq_vld_i      (enq_vld_i),
      .enq_issuable_i (enq_issuable_i),
      .enq_data_i     (enq_data_i),
      .enq_rdy_o      (enq_rdy_o),
      .wake_i         (wake_i),
      .deq_vld_o      (deq_vld_o),
      .deq_rdy_i      (deq_rdy_i),
      .deq_data_o     (deq_data_o),
      .deq_idx_o      (deq_idx_o),
      .full_o         (full_o),
      .empty_o        (empty_o)
`ifdef SPQ_OCCUPANCY_EN
      ,
      .count_o        (count_o)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic int nth_free(input int n);
      int c = 0;
      for (int e = 0; e < D; e++) begin
         if (!m_vld[e]) begin
            if (c == n) return e;
            c++;
         end
      end
      return -1;
   endfunction

   function automatic int nth_ready(input int n);
      int c = 0;
      for (int e = 0; e < D; e++) begin
         if (m_vld[e] && m_iss[e]) begin
            if (c == n) return e;
            c++;
         end
      end
      return -1;
   endfunction

   function automatic exp_t model_outputs();
      exp_t r;
      int   s;
      int   occ = 0;
      r.deq_vld  = 2'b00;
      r.deq_idx  = 6'd0;
      r.deq_data = 64'd0;
      r.enq_rdy  = 2'b00;
      for (int k = 0; k < 2; k++) r.enq_rdy[k] = (nth_free(k) >= 0);
      for (int j = 0; j < 2; j++) begin
         s = nth_ready(j);
         if (s >= 0) begin
            r.deq_vld[j]           = 1'b1;
            r.deq_idx[j*3 +: 3]    = 3'(s);
            r.deq_data[j*32 +: 32] = m_data[s];
         end
      end
      for (int e = 0; e < D; e++) occ += int'(m_vld[e]);
      r.full  = (occ == D);
      r.empty = (occ == 0);
      r.cnt   = 4'(occ);
      return r;
   endfunction

   task automatic model_clear();
      for (int e = 0; e < D; e++) begin
         m_vld[e]  = 1'b0;
         m_iss[e]  = 1'b0;
         m_data[e] = 32'd0;
      end
   endtask

   task automatic drive_idle();
      flush_i        = 1'b0;
      enq_vld_i      = 2'b00;
      enq_issuable_i = 2'b00;
      enq_data_i     = 64'd0;
      wake_i         = 8'h00;
      deq_rdy_i      = 2'b00;
   endtask

   // One clock of stimulus: predict this cycle's outputs, drive, advance model.
   task automatic cycle(input logic [1:0] ev, input logic [1:0] iv,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [7:0] wk, input logic [1:0] dr, input logic fl);
      int es [2];
      int ds [2];
      bit dq [D];
      @(negedge clk);
      exp_q.push_back(model_outputs());
      flush_i        = fl;
      enq_vld_i      = ev;
      enq_issuable_i = iv;
      enq_data_i     = {d1, d0};
      wake_i         = wk;
      deq_rdy_i      = dr;
      for (int k = 0; k < 2; k++) es[k] = nth_free(k);
      for (int j = 0; j < 2; j++) ds[j] = nth_ready(j);
      for (int e = 0; e < D; e++) dq[e] = 1'b0;
      if (fl) begin
         for (int e = 0; e < D; e++) begin
            m_vld[e] = 1'b0;
            m_iss[e] = 1'b0;
         end
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (ds[j] >= 0 && dr[j]) begin
               m_vld[ds[j]] = 1'b0;
               m_iss[ds[j]] = 1'b0;
               dq[ds[j]]    = 1'b1;
            end
         end
         for (int k = 0; k < 2; k++) begin
            if (es[k] >= 0 && ev[k]) begin
               m_vld[es[k]]  = 1'b1;
               m_iss[es[k]]  = iv[k];
               m_data[es[k]] = (k == 0) ? d0 : d1;
            end
         end
         for (int e = 0; e < D; e++) begin
            if (wk[e] && m_vld[e] && !dq[e]) m_iss[e] = 1'b1;
         end
      end
   endtask

   task automatic idle();
      cycle(2'b00, 2'b00, 32'd0, 32'd0, 8'h00, 2'b00, 1'b0);
   endtask

   task automatic peek();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every predicted cycle against what the DUT presents.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_deq_vld",  64'(deq_vld_o),  64'(mon_e.deq_vld));
            chk("sb_deq_idx",  64'(deq_idx_o),  64'(mon_e.deq_idx));
            chk("sb_deq_data", deq_data_o,      mon_e.deq_data);
            chk("sb_enq_rdy",  64'(enq_rdy_o),  64'(mon_e.enq_rdy));
            chk("sb_full",     64'(full_o),     64'(mon_e.full));
            chk("sb_empty",    64'(empty_o),    64'(mon_e.empty));
`ifdef SPQ_OCCUPANCY_EN
            chk("sb_count",    64'(count_o),    64'(mon_e.cnt));
`endif
         end
      end
   end

   initial begin
      rstn = 1'b0;
      drive_idle();
      model_clear();
      #12;
      chk("rst_deq_vld", 64'(deq_vld_o), 64'd0);
      chk("rst_deq_idx", 64'(deq_idx_o), 64'd0);
      chk("rst_deq_data", deq_data_o, 64'd0);
      chk("rst_enq_rdy", 64'(enq_rdy_o), 64'h3);
      chk("rst_full", 64'(full_o), 64'd0);
      chk("rst_empty", 64'(empty_o), 64'd1);
`ifdef SPQ_OCCUPANCY_EN
      chk("rst_count", 64'(count_o), 64'd0);
`endif
      @(negedge clk);
      rstn = 1'b1;

      // Two issuable arrivals appear on both dequeue ports next cycle.
      cycle(2'b11, 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 8'h00, 2'b00, 1'b0);
      peek();
      chk("enq2_deq_vld", 64'(deq_vld_o), 64'h3);
      chk("enq2_deq_idx", 64'(deq_idx_o), 64'({3'd1, 3'd0}));
      chk("enq2_deq_data", deq_data_o, {32'hBBBB_0002, 32'hAAAA_0001});
      chk("enq2_empty", 64'(empty_o), 64'd0);
`ifdef SPQ_OCCUPANCY_EN
      chk("enq2_count", 64'(count_o), 64'd2);
`endif
      cycle(2'b00, 2'b00, 32'd0, 32'd0, 8'h00, 2'b11, 1'b0);
      peek();
      chk("drain_empty", 64'(empty_o), 64'd1);

      // Fill with sleeping entries, then wake 2 and 5.
      for (int i = 0; i < 4; i++) cycle(2'b11, 2'b00, $urandom, $urandom, 8'h00, 2'b00, 1'b0);
      peek();
      chk("fill_full", 64'(full_o), 64'd1);
      chk("fill_enq_rdy", 64'(enq_rdy_o), 64'd0);
      chk("fill_deq_vld", 64'(deq_vld_o), 64'd0);
      cycle(2'b00, 2'b00, 32'd0, 32'd0, 8'h24, 2'b00, 1'b0);
      peek();
      chk("wake_deq_vld", 64'(deq_vld_o), 64'h3);
      chk("wake_deq_idx", 64'(deq_idx_o), 64'({3'd5, 3'd2}));

      // Entries 3 and 6 issuable; only port 0 accepts.
      cycle(2'b00, 2'b00, 32'd0, 32'd0, 8'h00, 2'b00, 1'b1);
      for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, $urandom, $urandom, 8'h00, 2'b00, 1'b0);
      cycle(2'b01, 2'b00, $urandom, 32'd0, 8'h00, 2'b00, 1'b0);
      cycle(2'b00, 2'b00, 32'd0, 32'd0, 8'h48, 2'b00, 1'b0);
      peek();
      chk("hold_pre_idx", 64'(deq_idx_o), 64'({3'd6, 3'd3}));
      cycle(2'b00, 2'b00, 32'd0, 32'd0, 8'h00, 2'b01, 1'b0);
      peek();
      chk("hold_deq_vld", 64'(deq_vld_o), 64'h1);
      chk("hold_deq_idx", 64'(deq_idx_o), 64'({3'd0, 3'd6}));

      // 7/8 full: dequeue entry 0 while enqueueing; new data lands in slot 7.
      cycle(2'b00, 2'b00, 32'd0, 32'd0, 8'h00, 2'b00, 1'b1);
      cycle(2'b11, 2'b01, 32'hD0D0_0000, 32'hD1D1_0001, 8'h00, 2'b00, 1'b0);
      for (int i = 0; i < 2; i++) cycle(2'b11, 2'b00, $urandom, $urandom, 8'h00, 2'b00, 1'b0);
      cycle(2'b01, 2'b00, $urandom, 32'd0, 8'h00, 2'b00, 1'b0);
      cycle(2'b01, 2'b00, 32'h7777_0007, 32'd0, 8'h00, 2'b01, 1'b0);
      peek();
      chk("reuse_full", 64'(full_o), 64'd0);
      chk("reuse_enq_rdy", 64'(enq_rdy_o), 64'h1);
      chk("reuse_deq_vld", 64'(deq_vld_o), 64'd0);
      cycle(2'b01, 2'b01, 32'h0000_CAFE, 32'd0, 8'h00, 2'b00, 1'b0);
      peek();
      chk("reuse0_deq_vld", 64'(deq_vld_o), 64'h1);
      chk("reuse0_deq_data", deq_data_o, 64'h0000_0000_0000_CAFE);
      chk("reuse0_full", 64'(full_o), 64'd1);
      cycle(2'b00, 2'b00, 32'd0, 32'd0, 8'h80, 2'b00, 1'b0);
      peek();
      chk("slot7_deq_idx", 64'(deq_idx_o), 64'({3'd7, 3'd0}));
      chk("slot7_deq_data", deq_data_o, {32'h7777_0007, 32'h0000_CAFE});

      // Flush wins over concurrent enqueue, dequeue and wake.
      cycle(2'b11, 2'b11, $urandom, $urandom, 8'hFF, 2'b11, 1'b1);
      peek();
      chk("flush_empty", 64'(empty_o), 64'd1);
      chk("flush_deq_vld", 64'(deq_vld_o), 64'd0);
      chk("flush_full", 64'(full_o), 64'd0);
`ifdef SPQ_OCCUPANCY_EN
      chk("flush_count", 64'(count_o), 64'd0);
`endif

      // Asynchronous reset with five entries resident.
      cycle(2'b11, 2'b10, $urandom, $urandom, 8'h00, 2'b00, 1'b0);
      cycle(2'b11, 2'b10, $urandom, $urandom, 8'h00, 2'b00, 1'b0);
      cycle(2'b01, 2'b01, $urandom, 32'd0, 8'h00, 2'b00, 1'b0);
      @(negedge clk);
      #3;
      drive_idle();
      rstn = 1'b0;
      #1;
      chk("arst_empty", 64'(empty_o), 64'd1);
      chk("arst_deq_vld", 64'(deq_vld_o), 64'd0);
      chk("arst_enq_rdy", 64'(enq_rdy_o), 64'h3);
      chk("arst_full", 64'(full_o), 64'd0);
      model_clear();
      @(negedge clk);
      rstn = 1'b1;

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cycle(2'($urandom), 2'($urandom), $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
               2'($urandom), ($urandom_range(0, 49) == 0));
      end
      idle();
      @(negedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
